// File: rtl/axi_wr_resp_gen.sv
// Slave-side AXI write-response generator.
// Queues accepted AW IDs and completed W bursts, pairs them strictly in order,
// and presents each pair as one registered B response held until BREADY.
module axi_wr_resp_gen #(
  parameter int unsigned ID_W  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] AWID,
  input  logic            AWVALID,
  input  logic            AWREADY,
  input  logic            WVALID,
  input  logic            WREADY,
  input  logic            WLAST,
  input  logic            wr_err,
  output logic            aw_full,
  output logic            w_full,
  output logic [ID_W-1:0] S_BID,
  output logic [1:0]      BRESP,
  output logic            BVALID,
  input  logic            BREADY,
  output logic            ovf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  logic [ID_W-1:0]  aw_mem [DEPTH];
  logic [PTR_W-1:0] aw_wp, aw_rp;
  logic [CNT_W-1:0] aw_cnt, aw_cnt_nxt;

  logic [DEPTH-1:0] w_mem;
  logic [PTR_W-1:0] w_wp, w_rp;
  logic [CNT_W-1:0] w_cnt, w_cnt_nxt;

  logic             err_acc;
  logic [0:0]       state, state_nxt;

  logic aw_fire, w_fire, b_fire;
  logic aw_push, w_push, w_last_fire, pop;

  // Handshake decode and queue push/pop qualification
  always_comb begin
    aw_fire     = AWVALID & AWREADY;
    w_fire      = WVALID & WREADY;
    b_fire      = BVALID & BREADY;
    w_last_fire = w_fire & WLAST;
    aw_push     = aw_fire & ~aw_full;
    w_push      = w_last_fire & ~w_full;
    // Emptiness uses registered counts, so same-cycle pushes are not yet eligible
    pop         = (aw_cnt != '0) && (w_cnt != '0) && ((state == IDLE) || b_fire);
    aw_cnt_nxt  = aw_cnt + CNT_W'(aw_push) - CNT_W'(pop);
    w_cnt_nxt   = w_cnt + CNT_W'(w_push) - CNT_W'(pop);
  end

  // Next-state logic for the output register FSM
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = RESP;
      RESP:    if (b_fire && !pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Queue storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (aw_push) aw_mem[aw_wp] <= AWID;
    if (w_push)  w_mem[w_wp]   <= err_acc | wr_err;
  end

  // Queue pointers, counts, full flags, error accumulator and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_wp   <= '0;
      aw_rp   <= '0;
      aw_cnt  <= '0;
      w_wp    <= '0;
      w_rp    <= '0;
      w_cnt   <= '0;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      err_acc <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (aw_push) aw_wp <= aw_wp + PTR_W'(1);
      if (w_push)  w_wp  <= w_wp + PTR_W'(1);
      if (pop) begin
        aw_rp <= aw_rp + PTR_W'(1);
        w_rp  <= w_rp + PTR_W'(1);
      end
      aw_cnt  <= aw_cnt_nxt;
      w_cnt   <= w_cnt_nxt;
      aw_full <= (aw_cnt_nxt == CNT_W'(DEPTH));
      w_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
      if (w_fire) err_acc <= WLAST ? 1'b0 : (err_acc | wr_err);
      if ((aw_fire && aw_full) || (w_last_fire && w_full)) ovf <= 1'b1;
    end
  end

  // Registered B outputs, reloaded only when a pair is popped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      BVALID <= 1'b0;
      S_BID  <= '0;
      BRESP  <= 2'b00;
    end else begin
      BVALID <= (state_nxt == RESP);
      if (pop) begin
        S_BID <= aw_mem[aw_rp];
        BRESP <= w_mem[w_rp] ? 2'b10 : 2'b00;
      end
    end
  end

endmodule
